uart_inst_loader: RTL
=====================

# uart_inst_loader

Turns the UART receive byte stream into paced instruction issues for the sequencer. This is the receive-side companion to the switch/button stepping path. Each received byte is one 8-bit instruction word. Bytes are buffered in a small FIFO and issued one at a time as single-cycle `o_inst_valid` pulses, with a minimum gap between issues. SEND-class instructions (opcode `[7:6]==2'b11`) are held back until the UART transmitter is idle, so sequencer output is never dropped.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^`DEPTH_LOG2` bytes (16).
- `GAP_CYCLES`, default 16: idle cycles inserted after each issue. Legal range 1..255.

Ports:
- `clk`, input, 1: system clock (100 MHz).
- `rst`, input, 1: reset. Asynchronous, active-high. Clears all state.
- `i_rx_data`, input, 8: received byte from the UART controller.
- `i_rx_valid`, input, 1: single-cycle strobe; `i_rx_data` is valid in that cycle.
- `i_tx_busy`, input, 1: UART transmitter busy.
- `o_inst`, output, 8: instruction word to the sequencer. Registered.
- `o_inst_valid`, output, 1: single-cycle issue strobe. Registered.
- `o_inst_cnt`, output, 8: count of issued instructions, wraps 255→0.
- `o_level`, output, `DEPTH_LOG2`+1: current FIFO occupancy.
- `o_ovf`, output, 1: sticky overflow flag.

## Operation
**FIFO**
- Circular buffer with write and read pointers of width `DEPTH_LOG2`+1. Full/empty are decided by pointer MSB compare.
- Push: `i_rx_valid` and (not full, or a pop in the same cycle).
- Push rejected when full and no pop: byte dropped, `o_ovf` set to 1. `o_ovf` clears only on `rst`.
- Pop occurs in the ISSUE state only.

**FSM states**
- IDLE:
  - FIFO empty → stay.
  - Head `[7:6]==2'b11` and `i_tx_busy` → WAIT_TX.
  - Otherwise → ISSUE.
- WAIT_TX: stay while `i_tx_busy`. When `i_tx_busy`=0 → ISSUE. `i_tx_busy` is not re-sampled in ISSUE.
- ISSUE: `o_inst_valid`=1 and `o_inst`=head for exactly this cycle. Pop, increment `o_inst_cnt`, load gap counter with `GAP_CYCLES` → GAP.
- GAP: decrement the counter each cycle. After `GAP_CYCLES` cycles in GAP → IDLE.

**Output rules**
- `o_inst` holds the last issued value between issues.
- `o_inst_valid` is never high for two consecutive cycles.
- Receive path is independent of FSM state: pushes are accepted in every state.

**Reset**
- Asynchronous.
- Values: pointers 0, state IDLE, `o_inst`=0, `o_inst_valid`=0, `o_inst_cnt`=0, `o_level`=0, `o_ovf`=0.
- Reset mid-issue or mid-gap discards FIFO contents and any pending instruction; nothing is issued after release until a new byte arrives.

## Timing
- Byte strobed in cycle t into an empty FIFO with FSM in IDLE: `o_inst_valid` is high in cycle t+2.
- Back-to-back issues from a non-empty FIFO: pulse spacing is `GAP_CYCLES`+2 cycles (ISSUE at n, GAP at n+1..n+G, IDLE at n+G+1, ISSUE at n+G+2).
- SEND held in WAIT_TX: issues 1 cycle after the first cycle with `i_tx_busy`=0.
- `o_level` updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- `o_inst_cnt` updates the cycle after the ISSUE cycle.

## Configuration
- `UART_INST_CRLF_FILTER_EN` defined: bytes 0x0D and 0x0A are discarded before the FIFO. They never push, never set `o_ovf`, and never issue. This allows terminal line endings.
- Not defined: every byte, including 0x0D and 0x0A, is pushed and issued as an instruction.

## Test plan
- Single byte: reset, push 0x15 at cycle t with `i_tx_busy`=0 → `o_inst_valid` high exactly at t+2 with `o_inst`=0x15, `o_inst_cnt`=1, `o_level` returns to 0.
- Burst pacing with `GAP_CYCLES`=16: push 0x01, 0x02, 0x03 on consecutive cycles → three pulses in order, spaced exactly 18 cycles apart.
- SEND hold: push 0xC0 while `i_tx_busy`=1 for 100 cycles → no pulse during the busy window; pulse with 0xC0 one cycle after `i_tx_busy` falls.
- Overflow with `DEPTH_LOG2`=4: hold `i_tx_busy`=1 and push 0xC0 ×17 → `o_level`=16, `o_ovf`=1. After releasing busy, exactly 16 issues occur, and `o_inst_cnt`=16.
- Full FIFO with simultaneous push and pop: with the FIFO full, the 17th byte lands in an ISSUE cycle → byte accepted, `o_ovf` stays 0.
- Reset mid-gap: assert `rst` during GAP with `o_level`=5 → all outputs 0 immediately; no pulses after release. Separately, with `UART_INST_CRLF_FILTER_EN` defined, push 0x0D, 0x0A, 0x07 → only 0x07 is issued.

Source files
------------

// File: rtl/uart_inst_loader.sv
// Buffers UART receive bytes and issues them as paced single-cycle instruction strobes.
// Optional `UART_INST_CRLF_FILTER_EN` drops 0x0D/0x0A bytes before they reach the FIFO.
module uart_inst_loader #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_tx_busy,
    output logic [7:0]          o_inst,
    output logic                o_inst_valid,
    output logic [7:0]          o_inst_cnt,
    output logic [DEPTH_LOG2:0] o_level,
    output logic                o_ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TX,
        S_ISSUE,
        S_GAP
    } state_t;

    state_t              state, state_nxt;
    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr, rptr;
    logic [7:0]          gap_cnt, gap_cnt_nxt;
    logic [7:0]          head;
    logic                empty, full, byte_ok, push, pop, head_send;

`ifdef UART_INST_CRLF_FILTER_EN
    assign byte_ok = (i_rx_data != 8'h0D) && (i_rx_data != 8'h0A);
`else
    assign byte_ok = 1'b1;
`endif

    assign head      = mem[rptr[DEPTH_LOG2-1:0]];
    assign head_send = (head[7:6] == 2'b11);
    assign empty     = (wptr == rptr);
    assign full      = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                       (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
    assign pop       = (state == S_ISSUE);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push      = i_rx_valid && byte_ok && (!full || pop);
    assign o_level   = wptr - rptr;

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nxt = (head_send && i_tx_busy) ? S_WAIT_TX : S_ISSUE;
                end
            end
            S_WAIT_TX: begin
                if (!i_tx_busy) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gap_cnt_nxt = 8'(GAP_CYCLES);
                state_nxt   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt <= 8'd1) begin
                    gap_cnt_nxt = 8'd0;
                    state_nxt   = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 8'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            gap_cnt      <= 8'd0;
            wptr         <= '0;
            rptr         <= '0;
            o_inst       <= 8'd0;
            o_inst_valid <= 1'b0;
            o_inst_cnt   <= 8'd0;
            o_ovf        <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr       <= rptr + 1'b1;
                o_inst_cnt <= o_inst_cnt + 8'd1;
            end
            if (i_rx_valid && byte_ok && full && !pop) begin
                o_ovf <= 1'b1;
            end
            // Output strobe is registered so it is high during the ISSUE cycle itself.
            o_inst_valid <= (state_nxt == S_ISSUE);
            if (state_nxt == S_ISSUE) begin
                o_inst <= head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= i_rx_data;
        end
    end

endmodule
